// File: rtl/vector_writeback.sv
// ============================================================================
// Module      : vector_writeback
// Description : Packs the vector-memory contents into DDR words and writes
//               them out as Avalon-style write transactions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vector_writeback #(
  parameter int D                 = 64,
  parameter int FIXED_POINT_WIDTH = 16,
  parameter int DDR_DATA_WIDTH    = 512,
  parameter int DDR_ADDR_WIDTH    = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  output logic                         in_ready_o,
  input  logic                         in_valid_i,
  input  logic [DDR_ADDR_WIDTH-1:0]    ddr_base_address_i,
  output logic                         done_o,
  output logic [$clog2(D)-1:0]         vector_addr_o,
  input  logic [FIXED_POINT_WIDTH-1:0] vector_r_data_i,
  output logic [DDR_ADDR_WIDTH-1:0]    ddr_address_o,
  output logic                         ddr_w_en_o,
  output logic [DDR_DATA_WIDTH-1:0]    ddr_w_data_o,
  input  logic                         ddr_waitrequest_n_i
);

  localparam int c_values_per_word = DDR_DATA_WIDTH / FIXED_POINT_WIDTH;
  localparam int c_num_writes      = D / c_values_per_word;
  localparam int c_lane_w          = (c_values_per_word > 1) ? $clog2(c_values_per_word) : 1;
  localparam int c_word_w          = $clog2(c_num_writes + 1);
  localparam int c_vaddr_w         = $clog2(D);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GATHER = 2'd1,
    S_WRITE  = 2'd2
  } state_t;

  state_t                      r_state;
  state_t                      w_state_next;
  logic [c_word_w-1:0]         r_word;
  logic [c_lane_w-1:0]         r_lane;
  logic [DDR_ADDR_WIDTH-1:0]   r_base;
  logic [DDR_DATA_WIDTH-1:0]   r_buffer;
  logic                        r_done;
  logic                        w_lane_last;
  logic                        w_word_last;
  logic                        w_accept;
  logic [c_vaddr_w-1:0]        w_vaddr;

  assign w_lane_last = (r_lane == c_lane_w'(c_values_per_word - 1));
  assign w_word_last = (r_word == c_word_w'(c_num_writes - 1));
  assign w_accept    = (r_state == S_WRITE) && ddr_waitrequest_n_i;
  assign w_vaddr     = c_vaddr_w'(int'(r_word) * c_values_per_word + int'(r_lane));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (in_valid_i) w_state_next = S_GATHER;
      S_GATHER: if (w_lane_last) w_state_next = S_WRITE;
      S_WRITE:  if (ddr_waitrequest_n_i) w_state_next = w_word_last ? S_IDLE : S_GATHER;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_word   <= '0;
      r_lane   <= '0;
      r_base   <= '0;
      r_buffer <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_accept && w_word_last;
      case (r_state)
        S_IDLE: begin
          if (in_valid_i) begin
            r_base <= ddr_base_address_i;
            r_word <= '0;
            r_lane <= '0;
          end
        end
        S_GATHER: begin
          // Lane 0 lands in the least-significant element slot.
          r_buffer[int'(r_lane)*FIXED_POINT_WIDTH +: FIXED_POINT_WIDTH] <= vector_r_data_i;
          r_lane <= w_lane_last ? '0 : r_lane + 1'b1;
        end
        S_WRITE: begin
          if (ddr_waitrequest_n_i) r_word <= r_word + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Unused outputs are forced to zero so downstream never sees stale data.
  assign in_ready_o    = (r_state == S_IDLE);
  assign done_o        = r_done;
  assign ddr_w_en_o    = (r_state == S_WRITE);
  assign ddr_address_o = ddr_w_en_o ? r_base + DDR_ADDR_WIDTH'(r_word) : '0;
  assign ddr_w_data_o  = ddr_w_en_o ? r_buffer : '0;
  assign vector_addr_o = (r_state == S_GATHER) ? w_vaddr : '0;

endmodule

`default_nettype wire

// File: tb/tb_vector_writeback.sv
// ============================================================================
// Module      : tb_vector_writeback
// Description : Directed self-checking bench for vector_writeback (D=8, 4x16b/word).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vector_writeback;

  logic        clk;
  logic        rst_ni;
  logic        in_ready;
  logic        in_valid;
  logic [31:0] base;
  logic        done;
  logic [2:0]  vaddr;
  logic [15:0] vdata;
  logic [31:0] ddr_addr;
  logic        ddr_en;
  logic [63:0] ddr_data;
  logic        wrn;

  logic [15:0] vmem [8];
  assign vdata = vmem[vaddr];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int idle_bad = 0;
  int unstable = 0;
  int T;

  int          acc_q[$];
  int          done_q[$];
  int          wr_cyc_q[$];
  logic [31:0] wr_addr_q[$];
  logic [63:0] wr_data_q[$];
  int          en_cnt;
  logic        prev_en;
  logic        prev_acc;
  logic [31:0] prev_addr;
  logic [63:0] prev_data;

  vector_writeback #(
    .D                (8),
    .FIXED_POINT_WIDTH(16),
    .DDR_DATA_WIDTH   (64),
    .DDR_ADDR_WIDTH   (32)
  ) dut (
    .clk_i              (clk),
    .rst_ni             (rst_ni),
    .in_ready_o         (in_ready),
    .in_valid_i         (in_valid),
    .ddr_base_address_i (base),
    .done_o             (done),
    .vector_addr_o      (vaddr),
    .vector_r_data_i    (vdata),
    .ddr_address_o      (ddr_addr),
    .ddr_w_en_o         (ddr_en),
    .ddr_w_data_o       (ddr_data),
    .ddr_waitrequest_n_i(wrn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Observe at the falling edge; inputs change 1ns after the rising edge.
  always @(negedge clk) begin
    if (rst_ni) begin
      if (in_valid && in_ready) acc_q.push_back(cyc);
      if (done) done_q.push_back(cyc);
      if (ddr_en) begin
        en_cnt = en_cnt + 1;
        if (prev_en && !prev_acc && (ddr_addr != prev_addr || ddr_data != prev_data))
          unstable = unstable + 1;
        if (wrn) begin
          wr_cyc_q.push_back(cyc);
          wr_addr_q.push_back(ddr_addr);
          wr_data_q.push_back(ddr_data);
        end
      end else if (ddr_addr != 32'h0 || ddr_data != 64'h0) begin
        idle_bad = idle_bad + 1;
      end
      prev_en   = ddr_en;
      prev_acc  = ddr_en && wrn;
      prev_addr = ddr_addr;
      prev_data = ddr_data;
    end else begin
      prev_en = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    acc_q.delete();
    done_q.delete();
    wr_cyc_q.delete();
    wr_addr_q.delete();
    wr_data_q.delete();
    en_cnt = 0;
  endtask

  task automatic load_seq();
    for (int i = 0; i < 8; i++) vmem[i] = 16'(i + 1);
  endtask

  // Presents one job request for a single cycle; T is that cycle.
  task automatic start_job(input logic [31:0] b);
    base     = b;
    in_valid = 1'b1;
    T        = cyc;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int want, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (done_q.size() >= want) break;
      tick();
    end
    check("done_timeout", 64'(done_q.size()), 64'(want));
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_done"},  64'(done),     64'd0);
    check({tag, "_en"},    64'(ddr_en),   64'd0);
    check({tag, "_addr"},  64'(ddr_addr), 64'd0);
    check({tag, "_data"},  ddr_data,      64'd0);
    check({tag, "_vaddr"}, 64'(vaddr),    64'd0);
  endtask

  initial begin
    rst_ni   = 1'b0;
    in_valid = 1'b0;
    base     = 32'h0;
    wrn      = 1'b1;
    en_cnt   = 0;
    prev_en  = 1'b0;
    prev_acc = 1'b0;
    prev_addr = '0;
    prev_data = '0;
    for (int i = 0; i < 8; i++) vmem[i] = 16'h0;
    tick();
    tick();
    check_reset_outputs("rst");
    rst_ni = 1'b1;
    tick();

    // Basic job
    load_seq();
    clear_log();
    start_job(32'h100);
    wait_done(1, 40);
    check("basic_nwr",   64'(wr_cyc_q.size()), 64'd2);
    check("basic_c0",    64'(wr_cyc_q[0] - T), 64'd5);
    check("basic_a0",    64'(wr_addr_q[0]),    64'h100);
    check("basic_d0",    wr_data_q[0],         64'h0004_0003_0002_0001);
    check("basic_c1",    64'(wr_cyc_q[1] - T), 64'd10);
    check("basic_a1",    64'(wr_addr_q[1]),    64'h101);
    check("basic_d1",    wr_data_q[1],         64'h0008_0007_0006_0005);
    check("basic_ndone", 64'(done_q.size()),   64'd1);
    check("basic_tdone", 64'(done_q[0] - T),   64'd11);
    check("basic_en",    64'(en_cnt),          64'd2);

    // Negative values
    for (int i = 0; i < 8; i++) vmem[i] = 16'h0;
    vmem[0] = 16'hFFFF;
    vmem[1] = 16'h8000;
    clear_log();
    start_job(32'h10);
    wait_done(1, 40);
    check("neg_d0", wr_data_q[0], 64'h0000_0000_8000_FFFF);
    check("neg_d1", wr_data_q[1], 64'h0);

    // Stall for 3 cycles at the first WRITE
    load_seq();
    clear_log();
    start_job(32'h40);
    repeat (4) tick();
    wrn = 1'b0;
    repeat (3) tick();
    wrn = 1'b1;
    wait_done(1, 40);
    check("stall_en",     64'(en_cnt),          64'd5);
    check("stall_stable", 64'(unstable),        64'd0);
    check("stall_c0",     64'(wr_cyc_q[0] - T), 64'd8);
    check("stall_a0",     64'(wr_addr_q[0]),    64'h40);
    check("stall_d0",     wr_data_q[0],         64'h0004_0003_0002_0001);
    check("stall_c1",     64'(wr_cyc_q[1] - T), 64'd13);
    check("stall_tdone",  64'(done_q[0] - T),   64'd14);

    // Address wrap
    clear_log();
    start_job(32'hFFFF_FFFF);
    wait_done(1, 40);
    check("wrap_a0", 64'(wr_addr_q[0]), 64'hFFFF_FFFF);
    check("wrap_a1", 64'(wr_addr_q[1]), 64'h0);

    // Reset during GATHER of word 1
    clear_log();
    start_job(32'h300);
    repeat (6) tick();
    rst_ni = 1'b0;
    #1;
    check_reset_outputs("midrst");
    check("midrst_nwr", 64'(wr_cyc_q.size()), 64'd1);
    tick();
    tick();
    rst_ni = 1'b1;
    repeat (15) tick();
    check("midrst_nowr",  64'(wr_cyc_q.size()), 64'd1);
    check("midrst_ndone", 64'(done_q.size()),   64'd0);
    vmem[0] = 16'h1234;
    vmem[7] = 16'hABCD;
    clear_log();
    start_job(32'h200);
    wait_done(1, 40);
    check("fresh_a0",    64'(wr_addr_q[0]),  64'h200);
    check("fresh_d0",    wr_data_q[0],       64'h0004_0003_0002_1234);
    check("fresh_a1",    64'(wr_addr_q[1]),  64'h201);
    check("fresh_d1",    wr_data_q[1],       64'hABCD_0007_0006_0005);
    check("fresh_tdone", 64'(done_q[0] - T), 64'd11);

    // Requests mid-job are ignored, base sampled only at acceptance
    load_seq();
    clear_log();
    start_job(32'h500);
    tick();
    in_valid = 1'b1;
    base     = 32'h999;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_done(1, 40);
    check("ign_nacc", 64'(acc_q.size()),     64'd1);
    check("ign_nwr",  64'(wr_cyc_q.size()),  64'd2);
    check("ign_a0",   64'(wr_addr_q[0]),     64'h500);
    check("ign_a1",   64'(wr_addr_q[1]),     64'h501);

    // Back-to-back jobs with in_valid held high
    clear_log();
    base     = 32'h400;
    in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (acc_q.size() >= 2) break;
      tick();
    end
    in_valid = 1'b0;
    check("b2b_nacc", 64'(acc_q.size()), 64'd2);
    wait_done(2, 40);
    check("b2b_gap",    64'(acc_q[1] - acc_q[0]), 64'd11);
    check("b2b_same",   64'(done_q[0]),           64'(acc_q[1]));
    check("b2b_nwr",    64'(wr_cyc_q.size()),     64'd4);
    check("b2b_a2",     64'(wr_addr_q[2]),        64'h400);
    check("b2b_d3",     wr_data_q[3],             64'h0008_0007_0006_0005);
    check("b2b_tdone2", 64'(done_q[1] - acc_q[1]), 64'd11);

    check("idle_outputs_zero", 64'(idle_bad), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
